// File: rtl/branch_history_unit_if.sv
// Fetch/resolve/PHT-update signal bundle for branch_history_unit.
// The slave modport is the unit itself; the master modport is the surrounding pipeline.
interface branch_history_unit_if #(
  parameter int TABLE_INDEX = 7,
  parameter int HIST_LEN    = 7,
  parameter int DEPTH       = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [15:0]            fetch_pc;
  logic                   br_fetch;
  logic                   pred_taken;
  logic                   br_ready;
  logic [TABLE_INDEX-1:0] pht_pred_ind;
  logic                   br_resolve;
  logic                   resolve_taken;
  logic                   flush;
  logic                   ld_pht;
  logic                   taken_in;
  logic [TABLE_INDEX-1:0] pht_taken_ind;
  logic                   mispredict;
  logic [HIST_LEN-1:0]    ghr_spec;
  logic [CNT_W-1:0]       count;

  modport slave (
    input  fetch_pc, br_fetch, pred_taken, br_resolve, resolve_taken, flush,
    output br_ready, pht_pred_ind, ld_pht, taken_in, pht_taken_ind, mispredict,
    output ghr_spec, count
  );

  modport master (
    output fetch_pc, br_fetch, pred_taken, br_resolve, resolve_taken, flush,
    input  br_ready, pht_pred_ind, ld_pht, taken_in, pht_taken_ind, mispredict,
    input  ghr_spec, count
  );
endinterface

// File: rtl/branch_history_unit.sv
// Speculative global history plus in-flight branch FIFO for a gshare predictor:
// forms the PHT read index at fetch and the PHT write port at resolution.
module branch_history_unit #(
  parameter int TABLE_INDEX = 7,
  parameter int HIST_LEN    = 7,
  parameter int DEPTH       = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_history_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TABLE_INDEX-1:0] idx_mem_r  [DEPTH];
  logic                   pred_mem_r [DEPTH];
  logic [HIST_LEN-1:0]    ghr_mem_r  [DEPTH];

  logic [PTR_W-1:0]       head_r, tail_r, head_n_s, tail_n_s;
  logic [CNT_W-1:0]       count_r, count_n_s;
  logic [HIST_LEN-1:0]    ghr_spec_r, ghr_spec_n_s;
  logic [HIST_LEN-1:0]    ghr_commit_r, ghr_commit_n_s;
  logic                   ld_pht_r, taken_in_r, mispredict_r;
  logic [TABLE_INDEX-1:0] pht_taken_ind_r;

  logic [TABLE_INDEX-1:0] ghr_ext_s, pred_ind_s, head_idx_s;
  logic [HIST_LEN-1:0]    head_ghr_s;
  logic                   head_pred_s, ready_s, pop_s, push_s, mis_s;

  // Index formation, queue control and next-state selection
  always_comb begin
    ghr_ext_s                = {TABLE_INDEX{1'b0}};
    ghr_ext_s[HIST_LEN-1:0]  = ghr_spec_r;
    pred_ind_s               = bus.fetch_pc[TABLE_INDEX:1] ^ ghr_ext_s;
    ready_s                  = (count_r != CNT_W'(DEPTH));
    pop_s                    = bus.br_resolve && (count_r != {CNT_W{1'b0}});
    head_idx_s               = idx_mem_r[head_r];
    head_pred_s              = pred_mem_r[head_r];
    head_ghr_s               = ghr_mem_r[head_r];
    mis_s                    = pop_s && (bus.resolve_taken != head_pred_s);
    push_s                   = bus.br_fetch && ready_s && !mis_s && !bus.flush;
    head_n_s                 = head_r;
    tail_n_s                 = tail_r;
    count_n_s                = count_r;
    ghr_spec_n_s             = ghr_spec_r;

    if (pop_s) begin
      ghr_commit_n_s = {ghr_commit_r[HIST_LEN-2:0], bus.resolve_taken};
    end else begin
      ghr_commit_n_s = ghr_commit_r;
    end

    // Flush restores the committed history, including a commit landing this same cycle
    if (bus.flush) begin
      head_n_s     = {PTR_W{1'b0}};
      tail_n_s     = {PTR_W{1'b0}};
      count_n_s    = {CNT_W{1'b0}};
      ghr_spec_n_s = ghr_commit_n_s;
    end else if (mis_s) begin
      head_n_s     = {PTR_W{1'b0}};
      tail_n_s     = {PTR_W{1'b0}};
      count_n_s    = {CNT_W{1'b0}};
      ghr_spec_n_s = {head_ghr_s[HIST_LEN-2:0], bus.resolve_taken};
    end else begin
      if (pop_s) begin
        head_n_s = head_r + PTR_W'(1'b1);
      end else begin
        head_n_s = head_r;
      end
      if (push_s) begin
        tail_n_s     = tail_r + PTR_W'(1'b1);
        ghr_spec_n_s = {ghr_spec_r[HIST_LEN-2:0], bus.pred_taken};
      end else begin
        tail_n_s     = tail_r;
        ghr_spec_n_s = ghr_spec_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_n_s = count_r + CNT_W'(1'b1);
        2'b01:   count_n_s = count_r - CNT_W'(1'b1);
        default: count_n_s = count_r;
      endcase
    end
  end

  // Pointer, occupancy and history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      ghr_spec_r   <= {HIST_LEN{1'b0}};
      ghr_commit_r <= {HIST_LEN{1'b0}};
    end else begin
      head_r       <= head_n_s;
      tail_r       <= tail_n_s;
      count_r      <= count_n_s;
      ghr_spec_r   <= ghr_spec_n_s;
      ghr_commit_r <= ghr_commit_n_s;
    end
  end

  // Entry storage; contents are only consumed while counted as valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      idx_mem_r[tail_r]  <= pred_ind_s;
      pred_mem_r[tail_r] <= bus.pred_taken;
      ghr_mem_r[tail_r]  <= ghr_spec_r;
    end
  end

  // PHT write port, one cycle after the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pht_r        <= 1'b0;
      mispredict_r    <= 1'b0;
      taken_in_r      <= 1'b0;
      pht_taken_ind_r <= {TABLE_INDEX{1'b0}};
    end else begin
      ld_pht_r     <= pop_s;
      mispredict_r <= mis_s;
      if (pop_s) begin
        taken_in_r      <= bus.resolve_taken;
        pht_taken_ind_r <= head_idx_s;
      end else begin
        taken_in_r      <= taken_in_r;
        pht_taken_ind_r <= pht_taken_ind_r;
      end
    end
  end

  assign bus.br_ready      = ready_s;
  assign bus.pht_pred_ind  = pred_ind_s;
  assign bus.ld_pht        = ld_pht_r;
  assign bus.taken_in      = taken_in_r;
  assign bus.pht_taken_ind = pht_taken_ind_r;
  assign bus.mispredict    = mispredict_r;
  assign bus.ghr_spec      = ghr_spec_r;
  assign bus.count         = count_r;
endmodule

// File: tb/tb_branch_history_unit.sv
// Self-checking bench for branch_history_unit against a queue-based reference model.
module tb_branch_history_unit;
  localparam int TI    = 7;
  localparam int HL    = 7;
  localparam int DP    = 8;
  localparam int TMASK = (1 << TI) - 1;
  localparam int HMASK = (1 << HL) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_history_unit_if #(.TABLE_INDEX(TI), .HIST_LEN(HL), .DEPTH(DP)) bus();
  branch_history_unit #(.TABLE_INDEX(TI), .HIST_LEN(HL), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int idx; int pred; int ghr; } ent_t;
  ent_t mq[$];
  int m_spec, m_commit, m_ld, m_mis, m_tin, m_tind;
  int total = 0;
  int bad   = 0;

  function automatic int m_pred_ind(input int fpc);
    return ((fpc >> 1) & TMASK) ^ m_spec;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_spec = 0; m_commit = 0; m_ld = 0; m_mis = 0; m_tin = 0; m_tind = 0;
  endtask

  task automatic drive(input int fpc, input int bf, input int pt, input int br, input int rt, input int fl);
    bus.fetch_pc      = fpc[15:0];
    bus.br_fetch      = bf[0];
    bus.pred_taken    = pt[0];
    bus.br_resolve    = br[0];
    bus.resolve_taken = rt[0];
    bus.flush         = fl[0];
    #1;
  endtask

  // Advance one clock and step the reference model with the inputs presented
  task automatic tick();
    int pop, push, pidx, rt, pt;
    ent_t e;
    @(posedge clk);
    rt   = int'(bus.resolve_taken);
    pt   = int'(bus.pred_taken);
    pidx = m_pred_ind(int'(bus.fetch_pc));
    pop  = (bus.br_resolve && mq.size() > 0) ? 1 : 0;
    push = (bus.br_fetch && mq.size() < DP) ? 1 : 0;
    m_ld = 0; m_mis = 0;
    if (pop != 0) begin
      e = mq[0];
      m_ld = 1; m_tin = rt; m_tind = e.idx;
      m_mis = (rt != e.pred) ? 1 : 0;
      m_commit = ((m_commit << 1) | rt) & HMASK;
    end
    if (bus.flush) begin
      mq.delete(); m_spec = m_commit;
    end else if (m_mis != 0) begin
      mq.delete(); m_spec = ((e.ghr << 1) | rt) & HMASK;
    end else begin
      if (pop != 0) void'(mq.pop_front());
      if (push != 0) begin
        mq.push_back('{pidx, pt, m_spec});
        m_spec = ((m_spec << 1) | pt) & HMASK;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(16'h0046, 0, 0, 0, 0, 0);
    total++; if (bus.pht_pred_ind !== 7'h23) begin bad++; $display("FAIL reset_idx got=%h exp=23", bus.pht_pred_ind); end
    total++; if (bus.ghr_spec !== 7'h00) begin bad++; $display("FAIL reset_ghr got=%h exp=00", bus.ghr_spec); end
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.br_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.br_ready); end
    total++; if (bus.ld_pht !== 1'b0 || bus.mispredict !== 1'b0 || bus.taken_in !== 1'b0 || bus.pht_taken_ind !== 7'h00)
      begin bad++; $display("FAIL reset_upd got=%b%b%b%h exp=0000", bus.ld_pht, bus.mispredict, bus.taken_in, bus.pht_taken_ind); end
  endtask

  task automatic test_push_index();
    drive(16'h0046, 1, 1, 0, 0, 0);
    tick();
    total++; if (bus.ghr_spec !== 7'h01) begin bad++; $display("FAIL push_ghr got=%h exp=01", bus.ghr_spec); end
    total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL push_count got=%0d exp=1", bus.count); end
    drive(16'h0046, 0, 0, 0, 0, 0);
    total++; if (bus.pht_pred_ind !== 7'h22) begin bad++; $display("FAIL push_next_idx got=%h exp=22", bus.pht_pred_ind); end
  endtask

  task automatic test_resolve();
    drive(16'h0046, 0, 0, 1, 1, 0);
    tick();
    total++; if (bus.ld_pht !== 1'b1) begin bad++; $display("FAIL res_ld got=%b exp=1", bus.ld_pht); end
    total++; if (bus.pht_taken_ind !== 7'h23) begin bad++; $display("FAIL res_ind got=%h exp=23", bus.pht_taken_ind); end
    total++; if (bus.taken_in !== 1'b1 || bus.mispredict !== 1'b0) begin bad++; $display("FAIL res_dir got=%b%b exp=10", bus.taken_in, bus.mispredict); end
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL res_count got=%0d exp=0", bus.count); end
    drive(16'h0046, 0, 0, 0, 0, 0);
    tick();
    total++; if (bus.ld_pht !== 1'b0) begin bad++; $display("FAIL res_pulse got=%b exp=0", bus.ld_pht); end
    total++; if (bus.taken_in !== 1'b1 || bus.pht_taken_ind !== 7'h23) begin bad++; $display("FAIL res_hold got=%b%h exp=123", bus.taken_in, bus.pht_taken_ind); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0100 + 2 * i, 1, 1, 0, 0, 0);
      tick();
    end
    total++; if (bus.ghr_spec !== 7'h07) begin bad++; $display("FAIL mis_pre_ghr got=%h exp=07", bus.ghr_spec); end
    drive(16'h0200, 0, 0, 1, 0, 0);
    tick();
    total++; if (bus.mispredict !== 1'b1 || bus.taken_in !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b%b exp=10", bus.mispredict, bus.taken_in); end
    total++; if (bus.count !== 4'd0 || bus.ghr_spec !== 7'h00) begin bad++; $display("FAIL mis_state got=%0d/%h exp=0/00", bus.count, bus.ghr_spec); end
    total++; if (bus.pht_taken_ind !== m_tind[TI-1:0]) begin bad++; $display("FAIL mis_ind got=%h exp=%h", bus.pht_taken_ind, m_tind); end
  endtask

  task automatic test_full();
    int saved, rt, br;
    apply_reset();
    for (int i = 0; i < DP; i++) begin
      drive($urandom_range(0, 65535), 1, $urandom_range(0, 1), 0, 0, 0);
      tick();
    end
    total++; if (bus.br_ready !== 1'b0 || bus.count !== 4'd8) begin bad++; $display("FAIL full_state got=%b/%0d exp=0/8", bus.br_ready, bus.count); end
    saved = m_spec;
    drive(16'h0ABC, 1, 1, 0, 0, 0);
    tick();
    total++; if (bus.ghr_spec !== saved[HL-1:0] || bus.count !== 4'd8) begin bad++; $display("FAIL full_drop got=%h/%0d exp=%h/8", bus.ghr_spec, bus.count, saved); end
    drive(16'h0ABC, 1, 1, 1, mq[0].pred, 0);
    tick();
    total++; if (bus.count !== 4'd7 || bus.ld_pht !== 1'b1) begin bad++; $display("FAIL full_pushpop got=%0d/%b exp=7/1", bus.count, bus.ld_pht); end
    for (int i = 0; i < 16; i++) begin
      br = $urandom_range(0, 1);
      rt = (mq.size() > 0) ? mq[0].pred : 0;
      drive($urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 1), br, rt, 0);
      total++; if (bus.pht_pred_ind !== m_pred_ind(int'(bus.fetch_pc)) || bus.br_ready !== (mq.size() < DP))
        begin bad++; $display("FAIL wrap_comb got=%h/%b exp=%h/%0d", bus.pht_pred_ind, bus.br_ready, m_pred_ind(int'(bus.fetch_pc)), mq.size() < DP); end
      tick();
      total++; if (bus.count !== mq.size() || bus.ghr_spec !== m_spec[HL-1:0] || bus.ld_pht !== m_ld[0] || bus.pht_taken_ind !== m_tind[TI-1:0])
        begin bad++; $display("FAIL wrap_state got=%0d/%h/%b/%h exp=%0d/%h/%0d/%h", bus.count, bus.ghr_spec, bus.ld_pht, bus.pht_taken_ind, mq.size(), m_spec, m_ld, m_tind); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(16'h0300 + 4 * i, 1, (i < 2) ? 1 : $urandom_range(0, 1), 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(16'h0000, 0, 0, 1, 1, 0);
      tick();
    end
    total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count); end
    drive(16'h0000, 0, 0, 0, 0, 1);
    tick();
    total++; if (bus.count !== 4'd0 || bus.ghr_spec !== 7'h03) begin bad++; $display("FAIL flush_state got=%0d/%h exp=0/03", bus.count, bus.ghr_spec); end
  endtask

  task automatic test_async_reset();
    drive(16'h0046, 1, 1, 0, 0, 0);
    tick();
    drive(16'h0046, 0, 0, 1, 1, 0);
    tick();
    total++; if (bus.ld_pht !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", bus.ld_pht); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.ld_pht !== 1'b0 || bus.count !== 4'd0 || bus.ghr_spec !== 7'h00)
      begin bad++; $display("FAIL areset_now got=%b/%0d/%h exp=0/0/00", bus.ld_pht, bus.count, bus.ghr_spec); end
    apply_reset();
  endtask

  task automatic test_random();
    int rt, fl;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rt = mq[0].pred;
      else rt = $urandom_range(0, 1);
      fl = ($urandom_range(0, 31) == 0) ? 1 : 0;
      drive($urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0, rt, fl);
      total++; if (bus.pht_pred_ind !== m_pred_ind(int'(bus.fetch_pc)) || bus.br_ready !== (mq.size() < DP))
        begin bad++; $display("FAIL rnd_comb cyc=%0d got=%h/%b exp=%h/%0d", i, bus.pht_pred_ind, bus.br_ready, m_pred_ind(int'(bus.fetch_pc)), mq.size() < DP); end
      tick();
      total++; if (bus.ld_pht !== m_ld[0] || bus.mispredict !== m_mis[0] || bus.taken_in !== m_tin[0] || bus.pht_taken_ind !== m_tind[TI-1:0])
        begin bad++; $display("FAIL rnd_upd cyc=%0d got=%b%b%b/%h exp=%0d%0d%0d/%h", i, bus.ld_pht, bus.mispredict, bus.taken_in, bus.pht_taken_ind, m_ld, m_mis, m_tin, m_tind); end
      total++; if (bus.count !== mq.size() || bus.ghr_spec !== m_spec[HL-1:0])
        begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d/%h exp=%0d/%h", i, bus.count, bus.ghr_spec, mq.size(), m_spec); end
    end
  endtask

  initial begin
    test_reset();
    test_push_index();
    test_resolve();
    test_mispredict();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
